// File: rtl/ne_window_accum.sv
// ne_window_accum: drops warm-up samples of the nonlinear-energy stream, then sums
// fixed windows of valid samples with saturation into a valid/ready result register.
// Optional build macro NE_THRESH_EN adds a threshold input and a registered detect flag.
module ne_window_accum #(
  parameter int unsigned input_width = 32,
  parameter int unsigned acc_width   = 48,
  parameter int unsigned window_len  = 256,
  parameter int unsigned warmup_len  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [input_width-1:0] din,
  input  logic                   din_valid,
  input  logic                   clr,
  output logic [acc_width-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_sat,
`ifdef NE_THRESH_EN
  input  logic [acc_width-1:0]   thresh,
  output logic                   dout_detect,
`endif
  output logic                   overrun
);

  localparam int unsigned CntW  = $clog2(window_len);
  localparam int unsigned WarmW = (warmup_len > 0) ? $clog2(warmup_len + 1) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(window_len - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'((warmup_len > 0) ? warmup_len - 1 : 0);

  localparam logic [acc_width-1:0] AccMax = {1'b0, {(acc_width - 1){1'b1}}};
  localparam logic [acc_width-1:0] AccMin = {1'b1, {(acc_width - 1){1'b0}}};

  typedef enum logic [0:0] {StWarmup, StAccum} state_e;

  localparam state_e StInit = (warmup_len == 0) ? StAccum : StWarmup;

  state_e               state_q, state_d;
  logic [WarmW-1:0]     warm_cnt_q, warm_cnt_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [acc_width-1:0] acc_q, acc_d;
  logic                 wsat_q, wsat_d;
  logic [acc_width-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 dout_sat_q, dout_sat_d;
  logic                 overrun_q, overrun_d;
  logic                 detect_q, detect_d;

  logic signed [acc_width:0] acc_ext, din_ext, sum_wide;
  logic [acc_width-1:0]      sum_sat;
  logic                      sum_ovf;
  logic                      win_close;
  logic                      slot_free;
  logic                      hit;

  // One guard bit above the accumulator detects signed overflow of the add.
  always_comb begin
    acc_ext  = {acc_q[acc_width-1], acc_q};
    din_ext  = {{(acc_width + 1 - input_width){din[input_width-1]}}, din};
    sum_wide = acc_ext + din_ext;
    sum_ovf  = sum_wide[acc_width] != sum_wide[acc_width-1];
    sum_sat  = sum_ovf ? (sum_wide[acc_width] ? AccMin : AccMax) : sum_wide[acc_width-1:0];
    win_close = (state_q == StAccum) && din_valid && (cnt_q == CntLast);
    // Accept and reload on the same edge is allowed.
    slot_free = !dout_valid_q || dout_ready;
  end

`ifdef NE_THRESH_EN
  // Threshold is sampled on the window-close edge together with the result.
  always_comb hit = $signed(sum_sat) > $signed(thresh);
`else
  always_comb hit = 1'b0;
`endif

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StInit;
      warm_cnt_q   <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      wsat_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sat_q   <= 1'b0;
      overrun_q    <= 1'b0;
      detect_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      wsat_q       <= wsat_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sat_q   <= dout_sat_d;
      overrun_q    <= overrun_d;
      detect_q     <= detect_d;
    end
  end

  // Next-state: warm-up ends after warmup_len valid samples; clr restarts it.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StInit;
    end else if (state_q == StWarmup && din_valid && warm_cnt_q == WarmLast) begin
      state_d = StAccum;
    end
  end

  // Counters, accumulator and the result slot.
  always_comb begin
    warm_cnt_d   = warm_cnt_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    wsat_d       = wsat_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_sat_d   = dout_sat_q;
    overrun_d    = overrun_q;
    detect_d     = detect_q;
    if (clr) begin
      warm_cnt_d   = '0;
      cnt_d        = '0;
      acc_d        = '0;
      wsat_d       = 1'b0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      dout_sat_d   = 1'b0;
      overrun_d    = 1'b0;
      detect_d     = 1'b0;
    end else begin
      if (dout_valid_q && dout_ready) begin
        dout_valid_d = 1'b0;
      end
      if (state_q == StWarmup && din_valid) begin
        warm_cnt_d = warm_cnt_q + 1'b1;
      end
      if (state_q == StAccum && din_valid) begin
        if (win_close) begin
          cnt_d  = '0;
          acc_d  = '0;
          wsat_d = 1'b0;
          if (slot_free) begin
            dout_d       = sum_sat;
            dout_sat_d   = wsat_q | sum_ovf;
            dout_valid_d = 1'b1;
            detect_d     = hit;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          acc_d  = sum_sat;
          wsat_d = wsat_q | sum_ovf;
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dout       = dout_q;
    dout_valid = dout_valid_q;
    dout_sat   = dout_sat_q;
    overrun    = overrun_q;
`ifdef NE_THRESH_EN
    dout_detect = detect_q;
`endif
  end

endmodule

// File: tb/tb_ne_window_accum.sv
// Testbench for ne_window_accum: directed scenarios plus randomized traffic, each cycle
// checked against a queue-based window-sum reference model.
module tb_ne_window_accum;

  localparam int unsigned InW  = 32;
  localparam int unsigned AccW = 33;
  localparam int unsigned Win  = 4;
  localparam int unsigned Warm = 2;

  localparam longint AccMaxL = (longint'(1) <<< (AccW - 1)) - 1;
  localparam longint AccMinL = -(longint'(1) <<< (AccW - 1));

  logic            clk = 1'b0;
  logic            rst;
  logic [InW-1:0]  din;
  logic            din_valid;
  logic            clr;
  logic [AccW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_sat;
  logic            overrun;
`ifdef NE_THRESH_EN
  logic [AccW-1:0] thresh;
  logic            dout_detect;
`endif

  int nvec = 0;
  int nmis = 0;

  // Reference model state.
  int              m_warm;
  longint          m_q[$];
  logic [AccW-1:0] e_dout;
  logic            e_dv, e_sat, e_ovr, e_det;

  ne_window_accum #(
    .input_width(InW),
    .acc_width  (AccW),
    .window_len (Win),
    .warmup_len (Warm)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sat   (dout_sat),
`ifdef NE_THRESH_EN
    .thresh     (thresh),
    .dout_detect(dout_detect),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_warm = 0;
    m_q.delete();
    e_dout = '0;
    e_dv   = 1'b0;
    e_sat  = 1'b0;
    e_ovr  = 1'b0;
    e_det  = 1'b0;
  endtask

  // Behaviour at one rising edge, from the inputs presented during the cycle.
  task automatic model_edge();
    longint s;
    bit     sat;
    bit     free;
    if (!rst || clr) begin
      model_reset();
    end else begin
      free = !e_dv || dout_ready;
      if (e_dv && dout_ready) e_dv = 1'b0;
      if (din_valid) begin
        if (m_warm < Warm) begin
          m_warm++;
        end else begin
          m_q.push_back(longint'($signed(din)));
          if (m_q.size() == Win) begin
            s   = 0;
            sat = 1'b0;
            foreach (m_q[i]) begin
              s += m_q[i];
              if (s > AccMaxL) begin
                s = AccMaxL;
                sat = 1'b1;
              end else if (s < AccMinL) begin
                s = AccMinL;
                sat = 1'b1;
              end
            end
            m_q.delete();
            if (free) begin
              e_dout = s[AccW-1:0];
              e_sat  = sat;
              e_dv   = 1'b1;
`ifdef NE_THRESH_EN
              e_det  = s > longint'($signed(thresh));
`endif
            end else begin
              e_ovr = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance through the edge, compare with the model.
  task automatic cycle(input logic v, input logic [InW-1:0] d, input logic r, input logic c);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    clr        = c;
    @(posedge clk);
    model_edge();
    #1;
    nvec++;
    if (dout_valid !== e_dv) begin
      nmis++;
      $display("FAIL model_dout_valid t=%0t got %b want %b", $time, dout_valid, e_dv);
    end
    if (e_dv) begin
      nvec++;
      if (dout !== e_dout || dout_sat !== e_sat) begin
        nmis++;
        $display("FAIL model_dout t=%0t got %h/%b want %h/%b", $time, dout, dout_sat,
                 e_dout, e_sat);
      end
    end
    nvec++;
    if (overrun !== e_ovr) begin
      nmis++;
      $display("FAIL model_overrun t=%0t got %b want %b", $time, overrun, e_ovr);
    end
`ifdef NE_THRESH_EN
    nvec++;
    if (dout_detect !== e_det) begin
      nmis++;
      $display("FAIL model_detect t=%0t got %b want %b", $time, dout_detect, e_det);
    end
`endif
  endtask

  task automatic expect_result(input string name, input longint want, input logic want_sat);
    logic [AccW-1:0] w;
    w = want[AccW-1:0];
    nvec++;
    if (dout_valid !== 1'b1 || dout !== w || dout_sat !== want_sat) begin
      nmis++;
      $display("FAIL %s got v=%b d=%h s=%b want v=1 d=%h s=%b", name, dout_valid, dout,
               dout_sat, w, want_sat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = '0;
    din_valid = 1'b0;
    clr = 1'b0;
    dout_ready = 1'b1;
`ifdef NE_THRESH_EN
    thresh = AccW'(5);
`endif
    model_reset();
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (dout !== '0 || dout_valid !== 1'b0 || dout_sat !== 1'b0 || overrun !== 1'b0) begin
      nmis++;
      $display("FAIL reset_state got d=%h v=%b s=%b o=%b want all 0", dout, dout_valid,
               dout_sat, overrun);
    end
  endtask

  task automatic test_basic();
    int seq[6] = '{100, 100, 1, 2, 3, 4};
    foreach (seq[i]) cycle(1'b1, InW'(seq[i]), 1'b1, 1'b0);
    expect_result("basic_sum", 10, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    nvec++;
    if (dout_valid !== 1'b0) begin
      nmis++;
      $display("FAIL basic_valid_drop got %b want 0", dout_valid);
    end
  endtask

  task automatic test_gaps();
    int seq[6] = '{100, 100, 1, 2, 3, 4};
    cycle(1'b0, '0, 1'b1, 1'b1);
    foreach (seq[i]) begin
      cycle(1'b1, InW'(seq[i]), 1'b1, 1'b0);
      if (i != 5) cycle(1'b0, InW'(999), 1'b1, 1'b0);
    end
    expect_result("gaps_sum", 10, 1'b0);
  endtask

  task automatic test_overrun();
    cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, InW'(50), 1'b0, 1'b0);
    repeat (4) cycle(1'b1, InW'(1), 1'b0, 1'b0);
    repeat (4) cycle(1'b1, InW'(2), 1'b0, 1'b0);
    expect_result("overrun_hold", 4, 1'b0);
    nvec++;
    if (overrun !== 1'b1) begin
      nmis++;
      $display("FAIL overrun_flag got %b want 1", overrun);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    nvec++;
    if (dout_valid !== 1'b0 || dout === AccW'(8)) begin
      nmis++;
      $display("FAIL overrun_accept got v=%b d=%h want v=0 d!=8", dout_valid, dout);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (2) cycle(1'b1, InW'(9), 1'b1, 1'b0);
    repeat (4) cycle(1'b1, InW'(-5), 1'b1, 1'b0);
    expect_result("b2b_neg", -20, 1'b0);
    repeat (4) cycle(1'b1, InW'(7), 1'b1, 1'b0);
    expect_result("b2b_pos", 28, 1'b0);
  endtask

  task automatic test_saturation();
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (2) cycle(1'b1, InW'(3), 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    expect_result("sat_pos", AccMaxL, 1'b1);
    repeat (4) cycle(1'b1, InW'(1), 1'b1, 1'b0);
    expect_result("sat_cleared", 4, 1'b0);
    repeat (4) cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    expect_result("sat_neg", AccMinL, 1'b1);
  endtask

  task automatic test_async_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, InW'(1), 1'b0, 1'b0);
    repeat (8) cycle(1'b1, InW'(3), 1'b0, 1'b0);
    repeat (2) cycle(1'b1, InW'(6), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    nvec++;
    if (dout !== '0 || dout_valid !== 1'b0 || dout_sat !== 1'b0 || overrun !== 1'b0) begin
      nmis++;
      $display("FAIL async_reset got d=%h v=%b s=%b o=%b want all 0", dout, dout_valid,
               dout_sat, overrun);
    end
    cycle(1'b1, InW'(77), 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) cycle(1'b1, InW'(500), 1'b1, 1'b0);
    cycle(1'b1, InW'(1), 1'b1, 1'b0);
    cycle(1'b1, InW'(2), 1'b1, 1'b0);
    cycle(1'b1, InW'(3), 1'b1, 1'b0);
    cycle(1'b1, InW'(4), 1'b1, 1'b0);
    expect_result("post_reset_warmup", 10, 1'b0);
    // Same sequence using the synchronous clear.
    dout_ready = 1'b0;
    repeat (4) cycle(1'b1, InW'(5), 1'b0, 1'b0);
    repeat (4) cycle(1'b1, InW'(5), 1'b0, 1'b0);
    repeat (2) cycle(1'b1, InW'(6), 1'b0, 1'b0);
    cycle(1'b1, InW'(123), 1'b0, 1'b1);
    nvec++;
    if (dout !== '0 || dout_valid !== 1'b0 || dout_sat !== 1'b0 || overrun !== 1'b0) begin
      nmis++;
      $display("FAIL sync_clear got d=%h v=%b s=%b o=%b want all 0", dout, dout_valid,
               dout_sat, overrun);
    end
    repeat (2) cycle(1'b1, InW'(500), 1'b1, 1'b0);
    repeat (4) cycle(1'b1, InW'(1), 1'b1, 1'b0);
    expect_result("post_clear_warmup", 4, 1'b0);
  endtask

  task automatic test_random();
    logic [InW-1:0] d;
    logic           v, r, c;
    int             k;
    for (int n = 0; n < 600; n++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) d = 32'h7FFF_FFFF;
      else if (k == 1) d = 32'h8000_0000;
      else d = InW'(int'($urandom_range(0, 2000)) - 1000);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 49) == 0);
`ifdef NE_THRESH_EN
      thresh = AccW'(int'($urandom_range(0, 4000)) - 2000);
`endif
      cycle(v, d, r, c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
